// File: rtl/ws2812_chain_driver.sv
// WS2812/SK6812 one-wire LED chain driver: streams pixels from a synchronous RAM as NRZ bit frames,
// prefetching the next pixel so consecutive pixels follow with no gap, then holds the latch interval.
module ws2812_chain_driver #(
    parameter int BPP       = 24,
    parameter int ADDR_W    = 6,
    parameter int MSB_FIRST = 1,
    parameter int RD_LAT    = 1,
    parameter int T0H       = 18,
    parameter int T0L       = 40,
    parameter int T1H       = 35,
    parameter int T1L       = 30,
    parameter int RES       = 2500
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W:0]   n_leds_i,
    input  logic              loop_en_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [BPP-1:0]    rd_data_i,
    output logic              dout_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;

    localparam int TMAX_A = (T0H > T0L) ? T0H : T0L;
    localparam int TMAX_B = (T1H > T1L) ? T1H : T1L;
    localparam int TMAX_C = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int TMAX   = (TMAX_C > RES) ? TMAX_C : RES;
    localparam int CNT_W  = $clog2(TMAX + 1);
    localparam int BIT_W  = (BPP > 1) ? $clog2(BPP) : 1;

    localparam logic [CNT_W-1:0]  T0H_L   = CNT_W'(T0H - 1);
    localparam logic [CNT_W-1:0]  T0L_L   = CNT_W'(T0L - 1);
    localparam logic [CNT_W-1:0]  T1H_L   = CNT_W'(T1H - 1);
    localparam logic [CNT_W-1:0]  T1L_L   = CNT_W'(T1L - 1);
    localparam logic [CNT_W-1:0]  RES_L   = CNT_W'(RES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_L   = BIT_W'(BPP - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE = BIT_W'(1);
    localparam logic [ADDR_W:0]   PIX_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [ADDR_W:0]   pix_q, pix_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic              zdone_q, zdone_d;
    logic [BPP-1:0]    shift_q, shift_d;
    logic [BPP-1:0]    pbuf_q, pbuf_d;

    logic              rd_ok;
    logic              cur_bit;
    logic              hi_last;
    logic              lo_last;
    logic              last_pix;
    logic [BPP-1:0]    shift_next;

    assign rd_ok    = vld_q[RD_LAT-1];
    assign cur_bit  = (MSB_FIRST != 0) ? shift_q[BPP-1] : shift_q[0];
    assign hi_last  = cur_bit ? (cnt_q == T1H_L) : (cnt_q == T0H_L);
    assign lo_last  = cur_bit ? (cnt_q == T1L_L) : (cnt_q == T0L_L);
    assign last_pix = ((pix_q + PIX_ONE) == n_q);

    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_next = {shift_q[BPP-2:0], 1'b0};
        end else begin
            shift_next = {1'b0, shift_q[BPP-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pix_d   = pix_q;
        n_d     = n_q;
        addr_d  = addr_q;
        rd_en_d = 1'b0;
        zdone_d = 1'b0;
        shift_d = shift_q;
        pbuf_d  = pbuf_q;

        // Read-data valid tracks each strobe through the RAM latency.
        vld_d[0] = rd_en_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        if (rd_ok && (state_q != S_FETCH)) begin
            pbuf_d = rd_data_i;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (n_leds_i != '0) begin
                        n_d     = n_leds_i;
                        pix_d   = '0;
                        addr_d  = '0;
                        rd_en_d = 1'b1;
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (rd_ok) begin
                    shift_d = rd_data_i;
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                // First high cycle of a pixel launches the read for the following one.
                if ((cnt_q == '0) && (bit_q == '0) && !last_pix) begin
                    addr_d  = addr_q + ADR_ONE;
                    rd_en_d = 1'b1;
                end
                if (hi_last) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LOW: begin
                if (lo_last) begin
                    cnt_d = '0;
                    if (bit_q != BIT_L) begin
                        bit_d   = bit_q + BIT_ONE;
                        shift_d = shift_next;
                        state_d = S_HIGH;
                    end else if (!last_pix) begin
                        pix_d   = pix_q + PIX_ONE;
                        bit_d   = '0;
                        shift_d = pbuf_q;
                        state_d = S_HIGH;
                    end else begin
                        state_d = S_LATCH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LATCH: begin
                if (cnt_q == RES_L) begin
                    cnt_d = '0;
                    if (loop_en_i) begin
                        pix_d   = '0;
                        addr_d  = '0;
                        rd_en_d = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            vld_q   <= '0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            pix_q   <= pix_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            vld_q   <= vld_d;
            zdone_q <= zdone_d;
        end
    end

    // Pixel data registers carry no reset; the control path never consumes them stale.
    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
        pbuf_q  <= pbuf_d;
    end

    assign rd_en_o = rd_en_q;
    assign addr_o  = addr_q;
    assign dout_o  = (state_q == S_HIGH);
    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = zdone_q | ((state_q == S_LATCH) && (cnt_q == RES_L));

endmodule
